// File: rtl/rom_fetch_ctrl_if.sv
// Fetch-side bundle: ROM address/data, redirect/enable controls from execute,
// and the valid/ready instruction stream handed to decode.
interface rom_fetch_ctrl_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_pc;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  modport slave (
    input  fetch_en, redirect_valid, redirect_pc, rom_inst, out_ready,
    output rom_pc, out_valid, out_inst, out_pc, out_fault
  );

  modport master (
    output fetch_en, redirect_valid, redirect_pc, rom_inst, out_ready,
    input  rom_pc, out_valid, out_inst, out_pc, out_fault
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the ROM PC, tracks the 1-cycle ROM read
// latency and buffers fetched words in a 2-entry queue for decode.
module rom_fetch_ctrl #(
  parameter int          ROM_WORDS = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'hE1A0_0000
) (
  input  logic              clk,
  input  logic              rst,
  rom_fetch_ctrl_if.slave   bus
);

  localparam logic [31:0] ROM_LIMIT = 32'(4 * ROM_WORDS);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  logic [31:0] pc_q;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic        inflight_fault;
  entry_t      fifo_q [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  entry_t      head;

  assign bus.rom_pc    = pc_q;
  assign head          = fifo_q[rd_ptr];
  assign bus.out_valid = (count != 2'd0);

  // Outputs read as zero whenever the queue is empty, so the unreset storage
  // never leaks onto the decode interface.
  assign bus.out_inst  = bus.out_valid ? head.inst  : '0;
  assign bus.out_pc    = bus.out_valid ? head.pc    : '0;
  assign bus.out_fault = bus.out_valid ? head.fault : 1'b0;

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = inflight & ~bus.redirect_valid;

  // NOTE: the in-flight word already owns a slot, so space is judged on
  // queued + in-flight - leaving; this is what makes a push into a full queue impossible.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = bus.fetch_en & ~bus.redirect_valid & (occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_fault <= 1'b0;
      count          <= 2'd0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
    end else if (bus.redirect_valid) begin
      // Redirect flushes everything, including a same-cycle pop.
      pc_q     <= {bus.redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= pc_q;
        inflight_fault <= (pc_q >= ROM_LIMIT);
        pc_q           <= pc_q + 32'd4;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: queue storage is deliberately not reset; count and the output
  // masking define validity, so only control state needs a reset value.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_q[wr_ptr] <= '{inst:  inflight_fault ? NOP_INST : bus.rom_inst,
                          pc:    inflight_pc,
                          fault: inflight_fault};
    end
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl: a table-driven stall/stream scenario plus
// hand-written redirect, fetch-enable, PC-wrap and mid-stream reset sequences.
module tb_rom_fetch_ctrl;

  localparam logic [31:0] I0   = 32'hE3A0_2005;
  localparam logic [31:0] I1   = 32'hE3A0_3008;
  localparam logic [31:0] I2   = 32'hE083_4005;
  localparam logic [31:0] I3   = 32'hEA00_002A;
  localparam logic [31:0] NOP  = 32'hE1A0_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_fetch_ctrl_if bus ();

  rom_fetch_ctrl #(
    .ROM_WORDS (4),
    .RESET_PC  (32'h0000_0000),
    .NOP_INST  (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model with registered output; out-of-range reads return junk that the
  // controller must never pass on.
  logic [31:0] rom_img [4];
  always_ff @(posedge clk)
    bus.rom_inst <= (bus.rom_pc < 32'd16) ? rom_img[bus.rom_pc[3:2]] : JUNK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        en;
    logic        ready;
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        f;
    logic [31:0] rom_pc;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic ready, input logic v, input logic [31:0] inst,
                              input logic [31:0] pc, input logic f, input logic [31:0] rom_pc);
    vec_t r;
    r.en = 1'b1; r.ready = ready; r.v = v; r.inst = inst; r.pc = pc; r.f = f; r.rom_pc = rom_pc;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packs {valid, fault, inst, pc, rom_pc}; when nothing is expected in the
  // queue only valid and rom_pc are compared.
  task automatic expect_out(input string name, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic f, input logic [31:0] rom_pc);
    if (v)
      check(name, {30'b0, bus.out_valid, bus.out_fault, bus.out_inst, bus.out_pc, bus.rom_pc},
                  {30'b0, 1'b1, f, inst, pc, rom_pc});
    else
      check(name, {95'b0, bus.out_valid, bus.rom_pc}, {95'b0, 1'b0, rom_pc});
  endtask

  task automatic idle(input string name, input logic [31:0] rom_pc);
    expect_out(name, 1'b0, 32'h0, 32'h0, 1'b0, rom_pc);
  endtask

  task automatic head(input string name, input logic [31:0] inst, input logic [31:0] pc,
                      input logic f, input logic [31:0] rom_pc);
    expect_out(name, 1'b1, inst, pc, f, rom_pc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    check(name, {30'b0, bus.out_valid, bus.out_fault, bus.out_inst, bus.out_pc, bus.rom_pc},
                {30'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rom_img[0] = I0; rom_img[1] = I1; rom_img[2] = I2; rom_img[3] = I3;
    bus.fetch_en       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b1;

    // Stream, back-pressure for 5 cycles, resume, then run into the fault region.
    vecs[0]  = mk(1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 32'h00);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0, 32'h0,  1'b0, 32'h04);
    vecs[2]  = mk(1'b1, 1'b1, I0,    32'h0,  1'b0, 32'h08);
    vecs[3]  = mk(1'b0, 1'b1, I1,    32'h4,  1'b0, 32'h0C);
    vecs[4]  = mk(1'b0, 1'b1, I1,    32'h4,  1'b0, 32'h0C);
    vecs[5]  = mk(1'b0, 1'b1, I1,    32'h4,  1'b0, 32'h0C);
    vecs[6]  = mk(1'b0, 1'b1, I1,    32'h4,  1'b0, 32'h0C);
    vecs[7]  = mk(1'b0, 1'b1, I1,    32'h4,  1'b0, 32'h0C);
    vecs[8]  = mk(1'b1, 1'b1, I1,    32'h4,  1'b0, 32'h0C);
    vecs[9]  = mk(1'b1, 1'b1, I2,    32'h8,  1'b0, 32'h10);
    vecs[10] = mk(1'b1, 1'b1, I3,    32'hC,  1'b0, 32'h14);
    vecs[11] = mk(1'b1, 1'b1, NOP,   32'h10, 1'b1, 32'h18);
    vecs[12] = mk(1'b1, 1'b1, NOP,   32'h14, 1'b1, 32'h1C);

    do_reset();
    check_reset_state("reset_state");
    for (int i = 0; i < 13; i++) begin
      bus.fetch_en  = vecs[i].en;
      bus.out_ready = vecs[i].ready;
      expect_out($sformatf("table[%0d]", i), vecs[i].v, vecs[i].inst, vecs[i].pc,
                 vecs[i].f, vecs[i].rom_pc);
      step();
    end

    // Redirect to 0x7 while running, coinciding with a pop of I1@4.
    bus.out_ready = 1'b1;
    bus.fetch_en  = 1'b1;
    do_reset();
    idle("rd_r0", 32'h0);  step();
    idle("rd_r1", 32'h4);  step();
    head("rd_r2", I0, 32'h0, 1'b0, 32'h8);  step();
    head("rd_r3", I1, 32'h4, 1'b0, 32'hC);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0007;
    step();
    bus.redirect_valid = 1'b0;
    idle("rd_flush0", 32'h4);  step();
    idle("rd_flush1", 32'h8);  step();
    head("rd_target", I1, 32'h4, 1'b0, 32'hC);  step();
    head("rd_next", I2, 32'h8, 1'b0, 32'h10);

    // Redirect with fetch_en=0: nothing issues until fetch_en returns.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0008; bus.fetch_en = 1'b0;
    step();
    bus.redirect_valid = 1'b0;
    idle("rd_en0_a", 32'h8);  step();
    idle("rd_en0_b", 32'h8);  step();
    idle("rd_en0_c", 32'h8);
    bus.fetch_en = 1'b1;
    step();
    idle("rd_en1_a", 32'hC);  step();
    head("rd_en1_b", I2, 32'h8, 1'b0, 32'h10);

    // fetch_en dropped right after an issue: exactly one more word (I3@C) arrives.
    bus.fetch_en = 1'b0;
    step();
    head("en_drop_last", I3, 32'hC, 1'b0, 32'h10);  step();
    idle("en_drop_drain0", 32'h10);  step();
    idle("en_drop_drain1", 32'h10);
    bus.fetch_en = 1'b1;
    step();
    idle("en_resume0", 32'h14);  step();
    head("en_resume1", NOP, 32'h10, 1'b1, 32'h18);

    // Misaligned redirect near the top of the address space, then wrap to 0.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    idle("wrap_a", 32'hFFFF_FFFC);  step();
    idle("wrap_b", 32'h0);  step();
    head("wrap_top", NOP, 32'hFFFF_FFFC, 1'b1, 32'h4);  step();
    head("wrap_zero", I0, 32'h0, 1'b0, 32'h8);

    // Mid-stream reset with the queue full; ready=1 and redirect at the reset edge.
    bus.out_ready = 1'b0;
    do_reset();
    idle("mr_r0", 32'h0);  step();
    idle("mr_r1", 32'h4);  step();
    head("mr_r2", I0, 32'h0, 1'b0, 32'h8);  step();
    head("mr_full", I0, 32'h0, 1'b0, 32'h8);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0040;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    check_reset_state("mr_reset_state");
    step();
    idle("mr_restart0", 32'h4);  step();
    head("mr_restart1", I0, 32'h0, 1'b0, 32'h8);  step();
    head("mr_restart2", I1, 32'h4, 1'b0, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
